// File: rtl/isqrt_digit_seq.sv
// Sequential digit-by-digit integer square root: one root bit per clock, MSB pair first.
// Returns floor(sqrt(num)), the remainder and a perfect-square flag over valid/ready.
module isqrt_digit_seq #(
   parameter int WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     num,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH/2-1:0]   root,
   output logic [WIDTH/2:0]     rem,
   output logic                 exact
);

   localparam int RW = WIDTH / 2;
   localparam int CW = (RW > 1) ? $clog2(RW) : 1;

   generate
      if (WIDTH < 2 || (WIDTH % 2) != 0) begin : g_bad_width
         $error("isqrt_digit_seq: WIDTH must be even and >= 2");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_next;
   logic [WIDTH-1:0]  r_shift;
   logic [RW-1:0]     r_root;
   logic [RW:0]       r_rem;
   logic              r_exact;
   logic [CW-1:0]     r_cnt;

   logic [RW+2:0]     w_base;
   logic [RW+2:0]     w_trial;
   logic [RW+2:0]     w_diff;
   logic [RW+2:0]     w_rem_full;
   logic              w_ge;
   logic              w_last;
   logic [RW-1:0]     w_root_next;

   // Remainder stays <= 2*root, so the selected partial remainder always fits RW+1 bits.
   assign w_base      = {r_rem, r_shift[WIDTH-1 -: 2]};
   assign w_trial     = {1'b0, r_root, 2'b01};
   assign w_ge        = (w_base >= w_trial);
   assign w_diff      = w_base - w_trial;
   assign w_rem_full  = w_ge ? w_diff : w_base;
   assign w_root_next = (r_root << 1) | RW'(w_ge);
   assign w_last      = (r_cnt == '0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (in_valid)  w_state_next = S_CALC;
         S_CALC:  if (w_last)    w_state_next = S_DONE;
         S_DONE:  if (out_ready) w_state_next = S_IDLE;
         default:                w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_shift <= '0;
         r_root  <= '0;
         r_rem   <= '0;
         r_exact <= 1'b0;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_shift <= num;
                  r_root  <= '0;
                  r_rem   <= '0;
                  r_cnt   <= CW'(RW - 1);
               end
            end
            S_CALC: begin
               r_shift <= r_shift << 2;
               r_root  <= w_root_next;
               r_rem   <= w_rem_full[RW:0];
               r_cnt   <= r_cnt - CW'(1);
               if (w_last) begin
                  r_exact <= (w_rem_full == '0);
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign in_ready  = (r_state == S_IDLE);
   assign out_valid = (r_state == S_DONE);
   assign root      = r_root;
   assign rem       = r_rem;
   assign exact     = r_exact;

endmodule

// File: tb/tb_isqrt_digit_seq.sv
// Bench for isqrt_digit_seq: directed WIDTH=16 operations checked against an arithmetic
// reference, a WIDTH=6 corner case and an exhaustive WIDTH=8 sweep.
module tb_isqrt_digit_seq;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        iv16 = 1'b0, or16 = 1'b0;
   logic [15:0] num16 = '0;
   logic        ir16, ov16, ex16;
   logic [7:0]  root16;
   logic [8:0]  rem16;

   logic        iv8 = 1'b0, or8 = 1'b0;
   logic [7:0]  num8 = '0;
   logic        ir8, ov8, ex8;
   logic [3:0]  root8;
   logic [4:0]  rem8;

   logic        iv6 = 1'b0, or6 = 1'b0;
   logic [5:0]  num6 = '0;
   logic        ir6, ov6, ex6;
   logic [2:0]  root6;
   logic [3:0]  rem6;

   isqrt_digit_seq #(.WIDTH(16)) u_dut16 (
      .clk(clk), .reset(rst_n), .in_valid(iv16), .in_ready(ir16), .num(num16),
      .out_valid(ov16), .out_ready(or16), .root(root16), .rem(rem16), .exact(ex16));
   isqrt_digit_seq #(.WIDTH(8)) u_dut8 (
      .clk(clk), .reset(rst_n), .in_valid(iv8), .in_ready(ir8), .num(num8),
      .out_valid(ov8), .out_ready(or8), .root(root8), .rem(rem8), .exact(ex8));
   isqrt_digit_seq #(.WIDTH(6)) u_dut6 (
      .clk(clk), .reset(rst_n), .in_valid(iv6), .in_ready(ir6), .num(num6),
      .out_valid(ov6), .out_ready(or6), .root(root6), .rem(rem6), .exact(ex6));

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Largest r with r*r <= n, found by plain counting.
   function automatic int unsigned ref_root(input int unsigned n);
      int unsigned r = 0;
      while ((r + 1) * (r + 1) <= n) r++;
      return r;
   endfunction

   // Operands accepted by the 16-bit instance whose results are still owed.
   int unsigned exp_q[$];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exp_q.delete();
      end else begin
         if (iv16 && ir16) exp_q.push_back(int'(num16));
         if (ov16 && or16 && exp_q.size() > 0) void'(exp_q.pop_front());
      end
   end

   always @(negedge clk) begin : compare16
      int unsigned cn, cr;
      if (rst_n && ov16) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_out_valid", 1, 0);
         end else begin
            cn = exp_q[0];
            cr = ref_root(cn);
            chk("model_root16", root16, cr);
            chk("model_rem16", rem16, cn - cr * cr);
            chk("model_exact16", ex16, (cn == cr * cr) ? 1 : 0);
         end
      end
   end

   task automatic op16(input logic [15:0] n, input int hold,
                       input int e_root, input int e_rem, input int e_exact);
      int lat;
      lat = 0;
      while (!ir16 && lat < 50) begin @(posedge clk); #1; lat++; end
      chk("in_ready_before_accept", ir16, 1);
      iv16 = 1'b1; num16 = n;
      @(posedge clk); #1;
      iv16 = 1'b0; num16 = 16'($urandom);
      lat = 0;
      while (!ov16 && lat < 50) begin @(posedge clk); #1; lat++; end
      chk("latency16", lat, 8);
      chk("root16", root16, e_root);
      chk("rem16", rem16, e_rem);
      chk("exact16", ex16, e_exact);
      for (int i = 0; i < hold; i++) begin
         iv16 = i[0]; num16 = 16'($urandom);
         @(posedge clk); #1;
         chk("held_in_ready", ir16, 0);
         chk("held_out_valid", ov16, 1);
      end
      iv16 = 1'b0;
      or16 = 1'b1;
      @(posedge clk); #1;
      or16 = 1'b0;
      chk("out_valid_drop", ov16, 0);
      chk("in_ready_after_done", ir16, 1);
      $display("op16 num=%0d root=%0d rem=%0d exact=%0d latency=%0d hold=%0d",
               n, e_root, e_rem, e_exact, lat, hold);
   endtask

   task automatic op6(input logic [5:0] n, input int e_root, input int e_rem, input int e_exact);
      int lat;
      iv6 = 1'b1; num6 = n;
      @(posedge clk); #1;
      iv6 = 1'b0;
      lat = 0;
      while (!ov6 && lat < 50) begin @(posedge clk); #1; lat++; end
      chk("latency6", lat, 3);
      chk("root6", root6, e_root);
      chk("rem6", rem6, e_rem);
      chk("exact6", ex6, e_exact);
      or6 = 1'b1;
      @(posedge clk); #1;
      or6 = 1'b0;
      $display("op6 num=%0d root=%0d rem=%0d exact=%0d", n, root6, rem6, ex6);
   endtask

   task automatic sweep8();
      int lat;
      int unsigned r;
      for (int n = 0; n < 256; n++) begin
         iv8 = 1'b1; num8 = 8'(n);
         @(posedge clk); #1;
         iv8 = 1'b0;
         lat = 0;
         while (!ov8 && lat < 50) begin @(posedge clk); #1; lat++; end
         r = ref_root(n);
         chk("sweep8_latency", lat, 4);
         chk("sweep8_result", {root8, rem8, ex8},
             {4'(r), 5'(n - r * r), (n == r * r) ? 1'b1 : 1'b0});
         or8 = 1'b1;
         @(posedge clk); #1;
         or8 = 1'b0;
         $display("op8 num=%0d root=%0d rem=%0d exact=%0d", n, root8, rem8, ex8);
      end
   endtask

   task automatic back_to_back();
      int          acc[3];
      int          na;
      logic        take;
      logic [15:0] vals[3];
      vals[0] = 16'd9999; vals[1] = 16'd40000; vals[2] = 16'd12345;
      na = 0;
      num16 = vals[0]; iv16 = 1'b1; or16 = 1'b1;
      for (int c = 0; c < 60 && na < 3; c++) begin
         take = ir16 && iv16;
         @(posedge clk); #1;
         if (take) begin
            acc[na] = c;
            $display("b2b accept num=%0d cycle=%0d", vals[na], c);
            na++;
            if (na < 3) num16 = vals[na];
            else iv16 = 1'b0;
         end
      end
      chk("b2b_accepts", na, 3);
      if (na == 3) begin
         chk("b2b_spacing_1", acc[1] - acc[0], 10);
         chk("b2b_spacing_2", acc[2] - acc[1], 10);
      end
      repeat (12) begin @(posedge clk); #1; end
      or16 = 1'b0;
      chk("b2b_queue_drained", exp_q.size(), 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", ir16, 1);
      chk("rst_out_valid", ov16, 0);
      chk("rst_root", root16, 0);
      chk("rst_rem", rem16, 0);
      chk("rst_exact", ex16, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      op16(16'd144,   0, 12,  0,   1);
      op16(16'd143,   0, 11,  22,  0);
      op16(16'd0,     0, 0,   0,   1);
      op16(16'd1,     0, 1,   0,   1);
      op16(16'd65535, 0, 255, 510, 0);
      op16(16'd10000, 20, 100, 0,  1);
      back_to_back();

      // Abort num=144 partway through its fourth iteration.
      iv16 = 1'b1; num16 = 16'd144;
      @(posedge clk); #1;
      iv16 = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      #1;
      chk("abort_out_valid", ov16, 0);
      chk("abort_in_ready", ir16, 1);
      chk("abort_root", root16, 0);
      chk("abort_rem", rem16, 0);
      chk("abort_exact", ex16, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      op16(16'd81, 0, 9, 0, 1);

      op6(6'd63, 7, 14, 0);
      op6(6'd36, 6, 0, 1);
      sweep8();

      chk("final_queue_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
